// File: rtl/reseller_pkg.sv
// rtl/reseller_pkg.sv - shared constants and width helper for the vending datapath
package reseller_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed to hold values 0..value-1; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// rtl/tick_divider.sv - enable-gated prescaler producing one step per DIV enabled cycles
module tick_divider
    import reseller_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic step
);

    generate
        if (DIV <= 1) begin : g_wire
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst, clr};
            assign step = en;
        end else begin : g_pre
            localparam int PW = clog2(DIV);
            localparam logic [PW-1:0] LAST = PW'(DIV - 1);

            logic [PW-1:0] pre;

            assign step = en && (pre == LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pre <= '0;
                end else if (clr) begin
                    pre <= '0;
                end else if (en) begin
                    pre <= step ? '0 : pre + PW'(1);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - prescaled up/down modulo counter with clamped load and terminal-count pulse
module mod_counter
    import reseller_pkg::*;
#(
    parameter  int MOD   = 8,
    parameter  int DIV   = 1,
    localparam int WIDTH = clog2(MOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc
);

    localparam logic [WIDTH:0] MAXV = (WIDTH + 1)'(MOD - 1);

    logic           step;
    logic [WIDTH:0] out_x;
    logic [WIDTH:0] lv_x;
    logic [WIDTH:0] nxt;
    logic           unused_msb;

    tick_divider #(.DIV(DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .step (step)
    );

    // One spare bit so a WIDTH-wide load_val can be compared against MOD-1 without wrap.
    assign out_x = {1'b0, out};
    assign lv_x  = {1'b0, load_val};

    always_comb begin
        nxt = out_x;
        if (load) begin
            nxt = (lv_x > MAXV) ? MAXV : lv_x;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                nxt = (out_x >= MAXV) ? '0 : out_x + 1'b1;
            end else begin
                nxt = (out_x == '0) ? MAXV : out_x - 1'b1;
            end
        end
    end

    assign unused_msb = nxt[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= nxt[WIDTH-1:0];
        end
    end

    // rst gate keeps tc quiet while out is forced to 0 with DIV=1 and counting down.
    assign tc = !rst && step && !load &&
                ((up_dn == DIR_UP) ? (out_x == MAXV) : (out_x == '0));

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - randomized and directed checks of four mod_counter configurations against a reference model
module tb_mod_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [2:0] o0;
    logic [3:0] o1;
    logic [1:0] o2;
    logic [2:0] o3;
    logic       tc0, tc1, tc2, tc3;

    int compared = 0;
    int failed = 0;

    int mods [4] = '{8, 10, 4, 8};
    int divs [4] = '{1, 1, 3, 2};
    int wids [4] = '{3, 4, 2, 3};
    int m_cnt[4];
    int m_pre[4];

    always #5 clk = ~clk;

    mod_counter #(.MOD(8),  .DIV(1)) dut0 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[2:0]), .out(o0), .tc(tc0));
    mod_counter #(.MOD(10), .DIV(1)) dut1 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[3:0]), .out(o1), .tc(tc1));
    mod_counter #(.MOD(4),  .DIV(3)) dut2 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[1:0]), .out(o2), .tc(tc2));
    mod_counter #(.MOD(8),  .DIV(2)) dut3 (.clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_val(lv[2:0]), .out(o3), .tc(tc3));

    function automatic logic [3:0] get_out(int i);
        case (i)
            0:       return {1'b0, o0};
            1:       return o1;
            2:       return {2'b00, o2};
            default: return {1'b0, o3};
        endcase
    endfunction

    function automatic logic get_tc(int i);
        case (i)
            0:       return tc0;
            1:       return tc1;
            2:       return tc2;
            default: return tc3;
        endcase
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i] = 0;
            m_pre[i] = 0;
        end
    endfunction

    // A step happens on the DIV-th enabled cycle since the last restart.
    function automatic bit m_step(int i);
        return en && ((m_pre[i] + 1) % divs[i] == 0);
    endfunction

    function automatic logic m_tc(int i);
        int wrap_from;
        wrap_from = up_dn ? mods[i] - 1 : 0;
        return logic'(!rst && m_step(i) && !load && m_cnt[i] == wrap_from);
    endfunction

    function automatic void model_edge();
        int v;
        bit s;
        for (int i = 0; i < 4; i++) begin
            s = m_step(i);
            if (rst) begin
                m_cnt[i] = 0;
                m_pre[i] = 0;
            end else if (load) begin
                v = int'(lv) % (1 << wids[i]);
                m_cnt[i] = (v < mods[i]) ? v : mods[i] - 1;
                m_pre[i] = 0;
            end else if (en) begin
                if (s) m_cnt[i] = up_dn ? (m_cnt[i] + 1) % mods[i] : (m_cnt[i] + mods[i] - 1) % mods[i];
                m_pre[i] = (m_pre[i] + 1) % divs[i];
            end
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        model_clear();
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        en = 1'b1;
        up_dn = 1'b0;
        load = 1'b0;
        rst = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (get_out(i) !== 4'd0 || get_tc(i) !== 1'b0) begin
                failed++;
                $display("FAIL reset dut%0d out=%0d tc=%b expected out=0 tc=0", i, get_out(i), get_tc(i));
            end
        end
        @(posedge clk);
        model_edge();
        #1;
        rst = 1'b0;
    endtask

    task automatic test_free_run();
        do_reset();
        en = 1'b1;
        up_dn = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (get_out(i) !== 4'(m_cnt[i]) || get_tc(i) !== m_tc(i)) begin
                    failed++;
                    $display("FAIL free_run dut%0d cyc%0d out=%0d tc=%b expected out=%0d tc=%b", i, c, get_out(i), get_tc(i), m_cnt[i], m_tc(i));
                end
            end
            compared++;
            if (tc0 !== (o0 == 3'd7)) begin
                failed++;
                $display("FAIL free_run_tc_at_7 cyc%0d out=%0d tc=%b", c, o0, tc0);
            end
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic test_down_count();
        do_reset();
        en = 1'b1;
        up_dn = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (get_out(i) !== 4'(m_cnt[i]) || get_tc(i) !== m_tc(i)) begin
                    failed++;
                    $display("FAIL down_count dut%0d cyc%0d out=%0d tc=%b expected out=%0d tc=%b", i, c, get_out(i), get_tc(i), m_cnt[i], m_tc(i));
                end
            end
            compared++;
            if (o1 > 4'd9) begin
                failed++;
                $display("FAIL down_count_range out=%0d required below 10", o1);
            end
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic test_prescaler();
        int pulses;
        pulses = 0;
        do_reset();
        up_dn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            en = !(c >= 25 && c < 30);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (get_out(i) !== 4'(m_cnt[i]) || get_tc(i) !== m_tc(i)) begin
                    failed++;
                    $display("FAIL prescaler dut%0d cyc%0d out=%0d tc=%b expected out=%0d tc=%b", i, c, get_out(i), get_tc(i), m_cnt[i], m_tc(i));
                end
            end
            if (c < 24 && tc2 === 1'b1) pulses++;
            @(posedge clk);
            model_edge();
            #1;
        end
        compared++;
        if (pulses != 2) begin
            failed++;
            $display("FAIL prescaler_tc_count got %0d pulses expected 2", pulses);
        end
        en = 1'b1;
    endtask

    task automatic test_load();
        en = 1'b1;
        up_dn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            load = (c < 3);
            lv = (c == 0) ? 4'd9 : (c == 1) ? 4'd12 : 4'd5;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (get_out(i) !== 4'(m_cnt[i]) || get_tc(i) !== m_tc(i)) begin
                    failed++;
                    $display("FAIL load dut%0d cyc%0d out=%0d tc=%b expected out=%0d tc=%b", i, c, get_out(i), get_tc(i), m_cnt[i], m_tc(i));
                end
            end
            if (c == 1) begin
                compared++;
                if (o1 !== 4'd9 || tc1 !== 1'b0) begin
                    failed++;
                    $display("FAIL load_priority out=%0d tc=%b expected out=9 tc=0", o1, tc1);
                end
            end
            if (c == 2) begin
                compared++;
                if (o1 !== 4'd9) begin
                    failed++;
                    $display("FAIL load_clamp out=%0d expected 9", o1);
                end
            end
            if (c == 3) begin
                compared++;
                if (o1 !== 4'd5 || o3 !== 3'd5) begin
                    failed++;
                    $display("FAIL load_value out1=%0d out3=%0d expected 5 5", o1, o3);
                end
            end
            if (c == 4 || c == 5) begin
                compared++;
                if (o3 !== ((c == 4) ? 3'd5 : 3'd6)) begin
                    failed++;
                    $display("FAIL load_prescaler_restart cyc%0d out=%0d expected %0d", c, o3, (c == 4) ? 5 : 6);
                end
            end
            @(posedge clk);
            model_edge();
            #1;
        end
        load = 1'b0;
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        up_dn = 1'b1;
        for (int c = 0; c < 9; c++) begin
            load = (c == 0);
            lv = 4'd5;
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (get_out(i) !== 4'(m_cnt[i]) || get_tc(i) !== m_tc(i)) begin
                    failed++;
                    $display("FAIL async_reset dut%0d cyc%0d out=%0d tc=%b expected out=%0d tc=%b", i, c, get_out(i), get_tc(i), m_cnt[i], m_tc(i));
                end
            end
            if (c == 2) begin
                #2;
                rst = 1'b1;
                model_clear();
                #1;
                for (int i = 0; i < 4; i++) begin
                    compared++;
                    if (get_out(i) !== 4'd0 || get_tc(i) !== 1'b0) begin
                        failed++;
                        $display("FAIL async_reset_immediate dut%0d out=%0d tc=%b expected 0 0", i, get_out(i), get_tc(i));
                    end
                end
            end
            if (c == 4 || c == 5) begin
                compared++;
                if (o3 !== ((c == 4) ? 3'd0 : 3'd1)) begin
                    failed++;
                    $display("FAIL async_reset_release cyc%0d out=%0d expected %0d", c, o3, (c == 4) ? 0 : 1);
                end
            end
            @(posedge clk);
            model_edge();
            #1;
            if (c == 2) rst = 1'b0;
        end
    endtask

    task automatic test_direction();
        en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            load = (c == 0);
            lv = 4'd3;
            up_dn = (c == 0);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (get_out(i) !== 4'(m_cnt[i]) || get_tc(i) !== m_tc(i)) begin
                    failed++;
                    $display("FAIL direction dut%0d cyc%0d out=%0d tc=%b expected out=%0d tc=%b", i, c, get_out(i), get_tc(i), m_cnt[i], m_tc(i));
                end
            end
            if (c == 4) begin
                compared++;
                if (o0 !== 3'd0 || tc0 !== 1'b1) begin
                    failed++;
                    $display("FAIL direction_tc_at_0 out=%0d tc=%b expected out=0 tc=1", o0, tc0);
                end
            end
            if (c == 5) begin
                compared++;
                if (o0 !== 3'd7 || tc0 !== 1'b0) begin
                    failed++;
                    $display("FAIL direction_wrap out=%0d tc=%b expected out=7 tc=0", o0, tc0);
                end
            end
            @(posedge clk);
            model_edge();
            #1;
        end
        load = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en = ($urandom_range(0, 9) < 8);
            up_dn = $urandom_range(0, 1);
            load = ($urandom_range(0, 15) == 0);
            lv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                model_clear();
            end else begin
                rst = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                compared++;
                if (get_out(i) !== 4'(m_cnt[i]) || get_tc(i) !== m_tc(i) || int'(get_out(i)) >= mods[i]) begin
                    failed++;
                    $display("FAIL random dut%0d cyc%0d out=%0d tc=%b expected out=%0d tc=%b", i, c, get_out(i), get_tc(i), m_cnt[i], m_tc(i));
                end
            end
            @(posedge clk);
            model_edge();
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_free_run();
        test_down_count();
        test_prescaler();
        test_load();
        test_async_reset();
        test_direction();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo counter for the vending-controller datapath; successor to the fixed 3-bit free-running display-scan counter. Counts modulo `MOD` at a rate divided by an internal prescaler. Adds enable, up/down direction, synchronous load and a terminal-count pulse. Used for digit-scan selection, coin-timeout timing and dispense-step sequencing.

## Interface
Parameters:
- `MOD`, 8: counter modulus; `out` ranges over 0..MOD-1; legal values are 2 and above.
- `DIV`, 1: prescaler ratio; `out` steps once per `DIV` enabled cycles; legal values are 1 and above.
- `WIDTH`, clog2(MOD): derived localparam, width of `out` and `load_val`.

Ports:
- `clk`  in  1  rising-edge clock; one clock domain only.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable; gates the prescaler.
- `up_dn`  in  1  direction: 1 = count up, 0 = count down; sampled every cycle.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  WIDTH  value to load.
- `out`  out  WIDTH  registered count value.
- `tc`  out  1  terminal-count pulse, combinational; high in the cycle whose edge wraps `out`.

## Operation
- Reset (`rst` high) clears `out` and the prescaler to 0 at once, without waiting for a clock edge. `tc` is 0 during reset.
- Prescaler `pre` counts 0..DIV-1 and advances only when `en`=1.
- Internal `step` = `en` && (`pre` == DIV-1). With DIV=1, `step` = `en`.
- Priority at each rising edge: `rst`, then `load`, then `step`, then hold.
- Load:
  - If `load_val` < MOD, `out` <= `load_val`.
  - If `load_val` >= MOD, `out` <= MOD-1 (clamped).
  - `pre` <= 0. Load works regardless of `en`.
- Step up: `out` == MOD-1 gives 0; otherwise `out` + 1.
- Step down: `out` == 0 gives MOD-1; otherwise `out` - 1.
- `en` low: `out` and `pre` both hold.
- Terminal count: `tc` = `step` && !`load` && (`up_dn` ? `out` == MOD-1 : `out` == 0).
- Direction change mid-count takes effect on the next step. The prescaler phase is kept.
- Arithmetic is done at WIDTH+1 bits internally. `out` never holds a value of MOD or above, including when MOD is not a power of 2.

## Timing
- Latency: `out` updates on the rising edge that ends a cycle with `step` or `load` high. There is one cycle from the qualifying inputs to the visible value.
- `tc` is asserted in the same cycle as the wrapping `step`. `out` shows the wrapped value the next cycle.
- With `en` held high, `out` changes every `DIV` cycles and `tc` pulses once every MOD×DIV cycles. Each `tc` pulse is exactly one cycle wide.
- Load with step in the same cycle: load wins, `tc` = 0, and the prescaler restarts. The next step follows DIV enabled cycles later.
- Reset mid-count:
  - Outputs go to 0 immediately.
  - The first step after release comes DIV enabled cycles after the first rising edge following `rst` deassertion.
- No combinational path from `load_val` to `out`. `tc` depends combinationally on `en`, `load` and `up_dn`.

## Structure
- The shared header/package `reseller_pkg` holds:
  - the `clog2` constant function used for `WIDTH` and the prescaler width;
  - direction constants `DIR_UP` = 1 and `DIR_DOWN` = 0.
- One sub-module, `tick_divider`, with parameter `DIV` and ports `clk`, `rst`, `en`, `clr` and `step`. It contains the prescaler only.
- `clr` is driven by `load`. For DIV=1 the divider reduces to a wire.
- `mod_counter` contains the count register, wrap/clamp logic and `tc` decode.

## Test plan
- Reset and free-run (MOD=8, DIV=1): `en`=1, `up_dn`=1, release `rst`.
  - `out` runs 0,1,…,7,0; `tc` is high only in the cycle with `out`=7.
- Non-power-of-2 down count (MOD=10, DIV=1): `up_dn`=0 from reset.
  - `out` runs 0,9,8,…,0; `tc` is high while `out`=0 and a step occurs; `out` never reaches 10–15.
- Prescaler (MOD=4, DIV=3): `en`=1 for 24 cycles.
  - `out` changes every 3 cycles; `tc` pulses once every 12 cycles.
  - Drop `en` for 5 cycles mid-phase: `out` and `pre` both freeze.
- Load priority and clamp (MOD=10):
  - `load`=1, `load_val`=12 at `out`=9 with a step pending gives `out`=9 and `tc`=0 that cycle.
  - `load_val`=5 gives `out`=5, and the next step follows DIV cycles later.
- Async reset mid-count (MOD=8, DIV=2, `out`=5):
  - Pulse `rst` between clock edges: `out` goes to 0 before the next edge.
  - After release, the first increment occurs at the second enabled edge.
- Direction flip: at `out`=3 (MOD=8), switch `up_dn` 1 to 0.
  - Sequence continues 3,2,1,0,7; `tc` asserts at 0 and not at 7.
